// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - command-sequenced wrapper around an external fixed-latency ALU
module alu_seq #(
    parameter int unsigned LAT = 2
) (
    input  logic       clk,
    input  logic       en,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_a,
    input  logic [1:0] cmd_b,
    input  logic [1:0] cmd_s,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [1:0] alu_s,
    input  logic [3:0] alu_y,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_y,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_dz,
    output logic [7:0] op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT4   = 4'(LAT);
    localparam logic [1:0] OP_DIV = 2'd2;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_cmd_ready;
    logic [1:0] r_alu_a;
    logic [1:0] r_alu_b;
    logic [1:0] r_alu_s;
    logic       r_rsp_valid;
    logic [3:0] r_rsp_y;
    logic       r_rsp_carry;
    logic       r_rsp_zero;
    logic       r_rsp_dz;
    logic [7:0] r_op_cnt;

    logic w_accept;
    logic w_dz;

    // cmd_ready is held low for one edge after reset, so accept also needs it
    assign w_accept = r_cmd_ready && cmd_valid;
    assign w_dz     = (r_alu_s == OP_DIV) && (r_alu_b == 2'd0);

    always_ff @(posedge clk) begin
        if (!en) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_cmd_ready <= 1'b0;
            r_alu_a     <= 2'd0;
            r_alu_b     <= 2'd0;
            r_alu_s     <= 2'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= 4'd0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_rsp_dz    <= 1'b0;
            r_op_cnt    <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_a     <= cmd_a;
                        r_alu_b     <= cmd_b;
                        r_alu_s     <= cmd_s;
                        r_cnt       <= LAT4;
                        r_cmd_ready <= 1'b0;
                        r_state     <= WAIT;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    // One ALU input stage plus LAT output stages: capture at T0+LAT+1
                    if (r_cnt == 4'd0) begin
                        r_rsp_y     <= alu_y;
                        r_rsp_carry <= alu_carry;
                        r_rsp_zero  <= alu_zero;
                        r_rsp_dz    <= w_dz;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_cnt    <= r_op_cnt + 8'd1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign rsp_carry = r_rsp_carry;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_dz    = r_rsp_dz;
    assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with directed vectors
module tb_alu_seq;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       en = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_a = 2'd0;
    logic [1:0] cmd_b = 2'd0;
    logic [1:0] cmd_s = 2'd0;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [1:0] alu_s;
    logic [3:0] alu_y = 4'd0;
    logic       alu_carry = 1'b0;
    logic       alu_zero = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_y;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_dz;
    logic [7:0] op_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // expected {y, carry, zero, dz}
    logic [6:0] exp_q[$];

    alu_seq #(.LAT(LAT)) dut (
        .clk(clk), .en(en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_dz(rsp_dz),
        .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every response handshake
    always @(negedge clk) begin
        if (en && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                check("rsp_y", 32'(rsp_y), 32'(e[6:3]));
                check("rsp_carry", 32'(rsp_carry), 32'(e[2]));
                check("rsp_zero", 32'(rsp_zero), 32'(e[1]));
                check("rsp_dz", 32'(rsp_dz), 32'(e[0]));
            end
        end
    end

    // Wait for cmd_ready, present one command with its ALU result, return after the accept edge
    task automatic do_op(input logic [1:0] a, input logic [1:0] b, input logic [1:0] s,
                         input logic [3:0] y, input logic c, input logic z, input logic dz,
                         input logic push, output int acc_cyc);
        int k;
        k = 0;
        while (!cmd_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) check("cmd_ready_timeout", 32'd0, 32'd1);
        cmd_a     = a;
        cmd_b     = b;
        cmd_s     = s;
        alu_y     = y;
        alu_carry = c;
        alu_zero  = z;
        cmd_valid = 1'b1;
        if (push) exp_q.push_back({y, c, z, dz});
        tick();
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int t_acc;
        int t_prev;
        int k;
        logic seen;
        logic [3:0] hold_y;
        logic [7:0] hold_cnt;

        // Reset with a pending command
        cmd_a = 2'd3; cmd_b = 2'd2; cmd_s = 2'd1; cmd_valid = 1'b1;
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_s", 32'(alu_s), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp", 32'({rsp_y, rsp_carry, rsp_zero, rsp_dz}), 32'd0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
        cmd_valid = 1'b0;
        en = 1'b1;
        tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_no_accept", 32'(alu_a), 32'd0);

        // Add 3+2 with detailed latency checks
        rsp_ready = 1'b1;
        do_op(2'd3, 2'd2, 2'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, t_acc);
        check("add_alu_a", 32'(alu_a), 32'd3);
        check("add_alu_b", 32'(alu_b), 32'd2);
        check("add_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        tick();
        tick();
        check("add_valid_early", 32'(rsp_valid), 32'd0);
        tick();
        check("add_valid_T0p3", 32'(rsp_valid), 32'd1);
        tick();
        check("add_op_cnt", 32'(op_cnt), 32'd1);
        check("add_cmd_ready_after", 32'(cmd_ready), 32'd1);

        // Divide by zero, then a valid divide
        do_op(2'd2, 2'd0, 2'd2, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, t_acc);
        do_op(2'd2, 2'd1, 2'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, t_acc);

        // Backpressure: response must hold, stray commands ignored
        k = 0;
        while (!cmd_ready && k < 50) begin tick(); k++; end
        rsp_ready = 1'b0;
        do_op(2'd1, 2'd1, 2'd3, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, t_acc);
        k = 0;
        while (!rsp_valid && k < 50) begin tick(); k++; end
        check("bp_valid", 32'(rsp_valid), 32'd1);
        hold_y   = rsp_y;
        hold_cnt = op_cnt;
        check("bp_rsp_y", 32'(hold_y), 32'd1);
        cmd_a = 2'd2; cmd_b = 2'd2; cmd_s = 2'd0; cmd_valid = 1'b1;
        alu_y = 4'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_y", 32'(rsp_y), 32'(hold_y));
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_alu_s", 32'(alu_s), 32'd3);
            check("bp_op_cnt", 32'(op_cnt), 32'(hold_cnt));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_release_op_cnt", 32'(op_cnt), 32'(hold_cnt + 8'd1));

        // Reset one cycle after accept aborts the command
        do_op(2'd1, 2'd2, 2'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, t_acc);
        en = 1'b0;
        tick();
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_op_cnt", 32'(op_cnt), 32'd0);
        check("abort_idle_ready", 32'(cmd_ready), 32'd1);

        // 256 back-to-back ops: wrap and fixed interval
        t_prev = 0;
        for (int i = 0; i < 256; i++) begin
            k = 0;
            while (!cmd_ready && k < 50) begin tick(); k++; end
            if (i == 255) check("wrap_255", 32'(op_cnt), 32'd255);
            do_op(2'(i), 2'(i >> 2), 2'd0, 4'(i), i[0], i[1], 1'b0, 1'b1, t_acc);
            if (i > 0) check("interval", 32'(t_acc - t_prev), 32'(LAT + 3));
            t_prev = t_acc;
        end
        k = 0;
        while (!cmd_ready && k < 50) begin tick(); k++; end
        check("wrap_0", 32'(op_cnt), 32'd0);

        k = 0;
        while (exp_q.size() != 0 && k < 50) begin tick(); k++; end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: LAT, default 2, ALU input-to-output register latency in cycles, range 0..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 en  input  1  reset, synchronous, active-low: en=0 at a rising clk edge resets the block.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_a, cmd_b  input  2 each  operands.
REQ-007 cmd_s  input  2  operation select: 0 add, 1 sub, 2 div, 3 mul.
REQ-008 alu_a, alu_b, alu_s  output  2 each  operands and select driven to the ALU.
REQ-009 alu_y  input  4  ALU result; alu_carry, alu_zero  input  1 each  ALU flags.
REQ-010 rsp_valid  output  1  result available; rsp_ready  input  1  consumer accepts.
REQ-011 rsp_y  output  4; rsp_carry, rsp_zero, rsp_dz  output  1 each  captured result, flags, divide-by-zero.
REQ-012 op_cnt  output  8  count of completed response handshakes.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, RESP.
REQ-014 cmd_ready SHALL be 1 only in IDLE, registered/decoded from state, never combinationally from cmd_valid.
REQ-015 IDLE: edge with cmd_valid=1 (accept edge T0) SHALL load alu_a/alu_b/alu_s from cmd_a/cmd_b/cmd_s, load 4-bit counter with LAT, go WAIT.
REQ-016 WAIT: counter SHALL decrement by 1 per edge while nonzero; at the edge where counter==0, capture alu_y/alu_carry/alu_zero into rsp_y/rsp_carry/rsp_zero, go RESP.
REQ-017 Capture edge SHALL be T0+LAT+1 (LAT=2: T0+3), accounting for one ALU input-register stage plus LAT output stages.
REQ-018 rsp_dz SHALL be set at capture to 1 iff latched alu_s==2 and alu_b==0, else 0; rsp_y passes alu_y unmodified.
REQ-019 RESP: rsp_valid=1; edge with rsp_ready=1 SHALL complete handshake, increment op_cnt modulo 256 (255->0), go IDLE.
REQ-020 While rsp_valid=1 and rsp_ready=0, rsp_y/rsp_carry/rsp_zero/rsp_dz SHALL hold stable.
REQ-021 alu_a/alu_b/alu_s SHALL hold from accept until the next accept, including through RESP and IDLE.
REQ-022 cmd_valid outside IDLE SHALL be ignored; no state, output, or counter change.
REQ-023 rsp_ready outside RESP SHALL be ignored.
REQ-024 Minimum command-to-command interval: LAT+3 cycles (accept T0, capture T0+LAT+1, earliest handshake T0+LAT+2, next accept T0+LAT+3).
REQ-025 LAT=0: capture SHALL occur at T0+1.

Reset
REQ-026 en=0 at an edge SHALL force state IDLE, counter 0, and all outputs 0: cmd_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_y, rsp_carry, rsp_zero, rsp_dz, op_cnt.
REQ-027 cmd_ready SHALL be 0 while en=0 and 1 from the first edge with en=1.
REQ-028 en=0 during WAIT or RESP SHALL abort: in-flight command discarded, no rsp_valid, op_cnt not incremented.
REQ-029 en=0 and cmd_valid=1 at the same edge: reset wins, command not accepted.

Verification
REQ-030 Reset: en=0 two cycles, cmd_valid=1 -> all outputs 0, cmd_ready=0; en=1 -> cmd_ready=1 after next edge, no accept during reset.
REQ-031 Add: cmd 3,2,s=0 at T0, ALU model y=5 carry=1 zero=0 -> alu_a=3 alu_b=2 after T0; rsp_valid=1 after T0+3, rsp_y=5 rsp_carry=1 rsp_zero=0 rsp_dz=0; rsp_ready=1 -> op_cnt=1, cmd_ready=1.
REQ-032 Div by zero: cmd 2,0,s=2, ALU model y=0 zero=1 -> rsp_dz=1, rsp_zero=1; cmd 2,1,s=2 -> rsp_dz=0, rsp_y=2.
REQ-033 Backpressure: rsp_ready=0 five cycles, cmd_valid=1 with 1,1,s=3 -> rsp outputs stable, cmd_ready=0, alu_s unchanged, op_cnt unchanged until rsp_ready=1.
REQ-034 Reset mid-WAIT: accept at T0, en=0 at T0+1 -> rsp_valid never 1, op_cnt=0, IDLE after reset release.
REQ-035 Wrap: 256 back-to-back ops with rsp_ready=1 -> op_cnt reads 255 then 0; interval per op exactly LAT+3 cycles.
